// File: rtl/scenario_table_feeder.sv
// Double-buffered delay-table sequencer feeding controller_integrated.
// Replays the active bank as boot or runtime strobes, optionally closing with an update pulse.
module scenario_table_feeder #(
  parameter int N_obj        = 4,
  parameter int delay_length = 14,
  parameter int obj_id_width = 2,
  parameter int slot_width   = 2,
  parameter int gap_cycles   = 1,
  parameter int upd_delay    = 4
) (
  input  logic                    CLK,
  input  logic                    reset_n,
  input  logic                    load_en,
  input  logic [slot_width-1:0]   load_slot,
  input  logic [delay_length-1:0] load_delay,
  input  logic [obj_id_width-1:0] load_obj_id,
  input  logic                    load_clear,
  input  logic                    commit,
  input  logic                    mode_runtime,
  input  logic                    gen_update,
  input  logic                    send_req,
  output logic [delay_length-1:0] delay_matrix_element,
  output logic [obj_id_width-1:0] obj_id_element,
  output logic                    input_valid,
  output logic                    glob_scen_noc_input_valid,
  output logic                    boot_up_table_update,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_GAP,
    S_WAIT,
    S_UPD
  } state_t;

  state_t state, state_n;

  logic [N_obj-1:0]        stg_v, stg_v_n, act_v;
  logic [delay_length-1:0] stg_d [N_obj];
  logic [delay_length-1:0] stg_d_n [N_obj];
  logic [delay_length-1:0] act_d [N_obj];
  logic [obj_id_width-1:0] stg_o [N_obj];
  logic [obj_id_width-1:0] stg_o_n [N_obj];
  logic [obj_id_width-1:0] act_o [N_obj];
  logic                    pend, copy;

  logic [3:0]              cnt, cnt_n;
  logic [slot_width-1:0]   cur, cur_n;
  logic                    rt_q, rt_n, gu_q, gu_n;
  logic                    done_n, upd_n, busy_n;
  logic [slot_width:0]     f0, fn;

  function automatic logic [slot_width:0] scan(
    input logic [N_obj-1:0]  v,
    input logic [slot_width:0] from
  );
    logic [slot_width:0] r;
    r = '0;
    for (int i = N_obj - 1; i >= 0; i--)
      if (v[i] && i >= int'(from))
        r = {1'b1, slot_width'(i)};
    return r;
  endfunction

  assign f0 = scan(act_v, '0);
  assign fn = scan(act_v, {1'b0, cur} + 1'b1);

  // Next staging image; a commit in this cycle copies it so same-edge loads land
  always_comb begin
    stg_v_n = stg_v;
    stg_d_n = stg_d;
    stg_o_n = stg_o;
    if (load_clear)
      stg_v_n = '0;
    if (load_en) begin
      stg_v_n[load_slot] = 1'b1;
      stg_d_n[load_slot] = load_delay;
      stg_o_n[load_slot] = load_obj_id;
    end
  end

  assign copy = !busy && (commit || pend);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      stg_v <= '0;
      act_v <= '0;
      pend  <= 1'b0;
      for (int i = 0; i < N_obj; i++) begin
        stg_d[i] <= '0;
        stg_o[i] <= '0;
        act_d[i] <= '0;
        act_o[i] <= '0;
      end
    end else begin
      stg_v <= stg_v_n;
      stg_d <= stg_d_n;
      stg_o <= stg_o_n;
      if (copy) begin
        act_v <= stg_v_n;
        act_d <= stg_d_n;
        act_o <= stg_o_n;
      end
      pend <= copy ? 1'b0 : (pend | commit);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_n   = cur;
    rt_n    = rt_q;
    gu_n    = gu_q;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (send_req && !busy) begin
          rt_n = mode_runtime;
          gu_n = gen_update;
          if (f0[slot_width]) begin
            state_n = S_EMIT;
            cur_n   = f0[slot_width-1:0];
          end else begin
            done_n = 1'b1;
          end
        end
      end
      S_EMIT: begin
        cnt_n   = 4'(gap_cycles - 1);
        state_n = S_GAP;
      end
      S_GAP: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else if (fn[slot_width]) begin
          cur_n   = fn[slot_width-1:0];
          state_n = S_EMIT;
        end else if (rt_q && gu_q) begin
          if (upd_delay > gap_cycles) begin
            cnt_n   = 4'(upd_delay - gap_cycles - 1);
            state_n = S_WAIT;
          end else begin
            state_n = S_UPD;
          end
        end else begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0)
          cnt_n = cnt - 4'd1;
        else
          state_n = S_UPD;
      end
      S_UPD: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    upd_n  = (state_n == S_UPD);
    done_n = done_n | upd_n;
    busy_n = (state_n != S_IDLE) | done_n;
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state                     <= S_IDLE;
      cnt                       <= '0;
      cur                       <= '0;
      rt_q                      <= 1'b0;
      gu_q                      <= 1'b0;
      delay_matrix_element      <= '0;
      obj_id_element            <= '0;
      input_valid               <= 1'b0;
      glob_scen_noc_input_valid <= 1'b0;
      boot_up_table_update      <= 1'b0;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      overrun                   <= 1'b0;
    end else begin
      state                     <= state_n;
      cnt                       <= cnt_n;
      cur                       <= cur_n;
      rt_q                      <= rt_n;
      gu_q                      <= gu_n;
      input_valid               <= (state_n == S_EMIT) && !rt_n;
      glob_scen_noc_input_valid <= (state_n == S_EMIT) && rt_n;
      boot_up_table_update      <= upd_n;
      busy                      <= busy_n;
      done                      <= done_n;
      overrun                   <= overrun | (send_req & busy);
      if (state_n == S_EMIT) begin
        delay_matrix_element <= act_d[cur_n];
        obj_id_element       <= act_o[cur_n];
      end
    end
  end

endmodule

// File: tb/tb_scenario_table_feeder.sv
// Directed bench for scenario_table_feeder.
// Records outputs per cycle after send_req is sampled and checks each task's expectations.
module tb_scenario_table_feeder;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        load_en, load_clear, commit;
  logic [1:0]  load_slot;
  logic [13:0] load_delay;
  logic [1:0]  load_obj_id;
  logic        mode_runtime, gen_update, send_req;
  logic [13:0] delay_matrix_element;
  logic [1:0]  obj_id_element;
  logic        input_valid, glob_scen_noc_input_valid;
  logic        boot_up_table_update, busy, done, overrun;

  int checks = 0;
  int errors = 0;

  logic [13:0] r_dat [0:15];
  logic [1:0]  r_obj [0:15];
  logic        r_iv  [0:15];
  logic        r_gv  [0:15];
  logic        r_upd [0:15];
  logic        r_done[0:15];
  logic        r_busy[0:15];

  scenario_table_feeder dut (
    .CLK                       (CLK),
    .reset_n                   (reset_n),
    .load_en                   (load_en),
    .load_slot                 (load_slot),
    .load_delay                (load_delay),
    .load_obj_id               (load_obj_id),
    .load_clear                (load_clear),
    .commit                    (commit),
    .mode_runtime              (mode_runtime),
    .gen_update                (gen_update),
    .send_req                  (send_req),
    .delay_matrix_element      (delay_matrix_element),
    .obj_id_element            (obj_id_element),
    .input_valid               (input_valid),
    .glob_scen_noc_input_valid (glob_scen_noc_input_valid),
    .boot_up_table_update      (boot_up_table_update),
    .busy                      (busy),
    .done                      (done),
    .overrun                   (overrun)
  );

  always #5 CLK = ~CLK;

  task automatic load(input logic [1:0] s, input logic [1:0] o, input logic [13:0] d);
    load_en = 1'b1;
    load_slot = s;
    load_obj_id = o;
    load_delay = d;
    @(posedge CLK);
    #1 load_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(posedge CLK);
    #1 commit = 1'b0;
  endtask

  // Cycle c of the record is the c-th cycle after the edge that samples send_req
  task automatic do_send(input logic m, input logic g, input int n);
    mode_runtime = m;
    gen_update = g;
    send_req = 1'b1;
    @(posedge CLK);
    #1 send_req = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge CLK);
      r_dat[c]  = delay_matrix_element;
      r_obj[c]  = obj_id_element;
      r_iv[c]   = input_valid;
      r_gv[c]   = glob_scen_noc_input_valid;
      r_upd[c]  = boot_up_table_update;
      r_done[c] = done;
      r_busy[c] = busy;
      @(posedge CLK);
    end
    #1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if ({input_valid, glob_scen_noc_input_valid, boot_up_table_update} !== 3'b000) begin
      errors++;
      $display("FAIL reset_valids got %b exp 000",
               {input_valid, glob_scen_noc_input_valid, boot_up_table_update});
    end
    checks++;
    if ({busy, done, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status got %b exp 000", {busy, done, overrun});
    end
    checks++;
    if (delay_matrix_element !== 14'd0 || obj_id_element !== 2'd0) begin
      errors++;
      $display("FAIL reset_data got %0d/%0d exp 0/0", delay_matrix_element, obj_id_element);
    end
    @(posedge CLK);
    #1 reset_n = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_boot_burst();
    load(2'd0, 2'd1, 14'd10000);
    load(2'd1, 2'd0, 14'd10010);
    load(2'd2, 2'd2, 14'd12000);
    do_commit();
    do_send(1'b0, 1'b0, 10);
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if (r_iv[c] !== (c == 1 || c == 3 || c == 5)) begin
        errors++;
        $display("FAIL boot_iv c=%0d got %b", c, r_iv[c]);
      end
      checks++;
      if (r_gv[c] !== 1'b0 || r_upd[c] !== 1'b0) begin
        errors++;
        $display("FAIL boot_gv_upd c=%0d got %b%b exp 00", c, r_gv[c], r_upd[c]);
      end
      checks++;
      if (r_done[c] !== (c == 7)) begin
        errors++;
        $display("FAIL boot_done c=%0d got %b", c, r_done[c]);
      end
      checks++;
      if (r_busy[c] !== (c <= 7)) begin
        errors++;
        $display("FAIL boot_busy c=%0d got %b", c, r_busy[c]);
      end
    end
    checks++;
    if (r_dat[1] !== 14'd10000 || r_obj[1] !== 2'd1) begin
      errors++;
      $display("FAIL boot_e0 got %0d/%0d exp 10000/1", r_dat[1], r_obj[1]);
    end
    checks++;
    if (r_dat[2] !== 14'd10000) begin
      errors++;
      $display("FAIL boot_hold got %0d exp 10000", r_dat[2]);
    end
    checks++;
    if (r_dat[3] !== 14'd10010 || r_obj[3] !== 2'd0) begin
      errors++;
      $display("FAIL boot_e1 got %0d/%0d exp 10010/0", r_dat[3], r_obj[3]);
    end
    checks++;
    if (r_dat[5] !== 14'd12000 || r_obj[5] !== 2'd2) begin
      errors++;
      $display("FAIL boot_e2 got %0d/%0d exp 12000/2", r_dat[5], r_obj[5]);
    end
  endtask

  task automatic test_runtime_update();
    do_send(1'b1, 1'b1, 12);
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (r_gv[c] !== (c == 1 || c == 3 || c == 5) || r_iv[c] !== 1'b0) begin
        errors++;
        $display("FAIL rt_valids c=%0d got gv=%b iv=%b", c, r_gv[c], r_iv[c]);
      end
      checks++;
      if (r_upd[c] !== (c == 10) || r_done[c] !== (c == 10)) begin
        errors++;
        $display("FAIL rt_upd_done c=%0d got upd=%b done=%b", c, r_upd[c], r_done[c]);
      end
      checks++;
      if (r_busy[c] !== (c <= 10)) begin
        errors++;
        $display("FAIL rt_busy c=%0d got %b", c, r_busy[c]);
      end
    end
    checks++;
    if (r_dat[5] !== 14'd12000 || r_obj[5] !== 2'd2) begin
      errors++;
      $display("FAIL rt_e2 got %0d/%0d exp 12000/2", r_dat[5], r_obj[5]);
    end
  endtask

  task automatic test_back_to_back();
    do_send(1'b0, 1'b0, 7);
    checks++;
    if (r_done[7] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done1 got %b exp 1", r_done[7]);
    end
    do_send(1'b0, 1'b0, 3);
    checks++;
    if (r_iv[1] !== 1'b1 || r_dat[1] !== 14'd10000) begin
      errors++;
      $display("FAIL b2b_second iv=%b dat=%0d exp 1/10000", r_iv[1], r_dat[1]);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overrun got %b exp 0", overrun);
    end
    repeat (6) @(posedge CLK);
    #1;
  endtask

  task automatic test_sparse_empty();
    load_clear = 1'b1;
    load(2'd3, 2'd2, 14'd12000);
    load_clear = 1'b0;
    do_commit();
    do_send(1'b0, 1'b0, 5);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (r_iv[c] !== (c == 1) || r_done[c] !== (c == 3)) begin
        errors++;
        $display("FAIL sparse c=%0d got iv=%b done=%b", c, r_iv[c], r_done[c]);
      end
    end
    checks++;
    if (r_dat[1] !== 14'd12000 || r_obj[1] !== 2'd2) begin
      errors++;
      $display("FAIL sparse_data got %0d/%0d exp 12000/2", r_dat[1], r_obj[1]);
    end
    load_clear = 1'b1;
    @(posedge CLK);
    #1 load_clear = 1'b0;
    do_commit();
    do_send(1'b0, 1'b0, 3);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (r_iv[c] !== 1'b0 || r_done[c] !== (c == 1) || r_busy[c] !== (c == 1)) begin
        errors++;
        $display("FAIL empty c=%0d got iv=%b done=%b busy=%b", c, r_iv[c], r_done[c], r_busy[c]);
      end
    end
  endtask

  task automatic test_double_buffer();
    load(2'd0, 2'd1, 14'd10000);
    load(2'd1, 2'd0, 14'd10010);
    load(2'd2, 2'd2, 14'd12000);
    do_commit();
    fork
      do_send(1'b1, 1'b0, 10);
      begin
        @(posedge CLK);
        @(posedge CLK);
        #1;
        load(2'd1, 2'd0, 14'd10008);
        do_commit();
      end
    join
    checks++;
    if (r_gv[3] !== 1'b1 || r_dat[3] !== 14'd10010) begin
      errors++;
      $display("FAIL dbuf_cur gv=%b dat=%0d exp 1/10010", r_gv[3], r_dat[3]);
    end
    checks++;
    if (r_done[7] !== 1'b1 || r_upd[7] !== 1'b0) begin
      errors++;
      $display("FAIL dbuf_done done=%b upd=%b exp 1/0", r_done[7], r_upd[7]);
    end
    do_send(1'b1, 1'b0, 8);
    checks++;
    if (r_gv[3] !== 1'b1 || r_dat[3] !== 14'd10008 || r_obj[3] !== 2'd0) begin
      errors++;
      $display("FAIL dbuf_next gv=%b dat=%0d obj=%0d exp 1/10008/0", r_gv[3], r_dat[3], r_obj[3]);
    end
  endtask

  task automatic test_overrun_reset();
    fork
      do_send(1'b0, 1'b0, 8);
      begin
        @(posedge CLK);
        @(posedge CLK);
        #1 send_req = 1'b1;
        @(posedge CLK);
        #1 send_req = 1'b0;
      end
    join
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (r_iv[c] !== (c == 1 || c == 3 || c == 5) || r_done[c] !== (c == 7)) begin
        errors++;
        $display("FAIL ovr_burst c=%0d got iv=%b done=%b", c, r_iv[c], r_done[c]);
      end
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flag got %b exp 1", overrun);
    end
    mode_runtime = 1'b0;
    send_req = 1'b1;
    @(posedge CLK);
    #1 send_req = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (busy !== 1'b1 || delay_matrix_element !== 14'd10000) begin
      errors++;
      $display("FAIL gap_pre busy=%b dat=%0d exp 1/10000", busy, delay_matrix_element);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({input_valid, glob_scen_noc_input_valid, boot_up_table_update,
         busy, done, overrun} !== 6'b0 || delay_matrix_element !== 14'd0 ||
        obj_id_element !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset flags=%b dat=%0d obj=%0d exp 0",
               {input_valid, glob_scen_noc_input_valid, boot_up_table_update,
                busy, done, overrun}, delay_matrix_element, obj_id_element);
    end
    @(posedge CLK);
    #1 reset_n = 1'b1;
    do_send(1'b0, 1'b0, 4);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (r_iv[c] !== 1'b0 || r_done[c] !== (c == 1)) begin
        errors++;
        $display("FAIL post_reset c=%0d got iv=%b done=%b", c, r_iv[c], r_done[c]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    load_en = 1'b0;
    load_clear = 1'b0;
    commit = 1'b0;
    load_slot = '0;
    load_delay = '0;
    load_obj_id = '0;
    mode_runtime = 1'b0;
    gen_update = 1'b0;
    send_req = 1'b0;
    test_reset();
    test_boot_burst();
    test_runtime_update();
    test_back_to_back();
    test_sparse_empty();
    test_double_buffer();
    test_overrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
